// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the decoder-to-issue-stage control payload.
package riscv_pkg;

  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned LUI_SHIFT  = 12;

  localparam logic [OPCODE_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IMM   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 7'b0110111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd4;

  typedef enum logic [1:0] {SRC1_ZERO, SRC1_RS1, SRC1_IMM} src1_sel_e;
  typedef enum logic [1:0] {SRC2_ZERO, SRC2_RS2, SRC2_IMM, SRC2_LUI} src2_sel_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    src1_sel_e           src1_sel;
    src2_sel_e           src2_sel;
    logic                shift;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decode into ALU code, operand selects and controls.
module alu_ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output dec_t       dec
);

  logic [ALU_OP_W-1:0] f3_op;
  logic                f3_ok;
  logic                legal;

  // funct3 map shared by R-type and I-type ALU ops
  always_comb begin
    f3_op = ALU_ADD;
    f3_ok = 1'b1;
    case (funct3)
      3'b000:  f3_op = ALU_ADD;
      3'b101:  f3_op = ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      3'b111:  f3_op = ALU_AND;
      3'b001:  f3_op = ALU_SLL;
      default: f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec.alu_op    = ALU_ADD;
    dec.src1_sel  = SRC1_ZERO;
    dec.src2_sel  = SRC2_ZERO;
    dec.shift     = 1'b0;
    dec.reg_write = 1'b0;
    dec.mem_read  = 1'b0;
    dec.mem_write = 1'b0;
    dec.illegal   = 1'b0;
    legal         = 1'b1;
    case (opcode)
      OP_R, OP_IMM: begin
        // R-type rejects SUB and SRA; I-type only rejects SRAI (bit 30 is immediate otherwise)
        if (opcode == OP_R)
          legal = f3_ok && !(funct7_b5 && (funct3 == 3'b000 || funct3 == 3'b101));
        else
          legal = f3_ok && !(funct7_b5 && funct3 == 3'b101);
        if (legal) begin
          dec.alu_op    = f3_op;
          dec.src1_sel  = SRC1_RS1;
          dec.src2_sel  = (opcode == OP_R) ? SRC2_RS2 : SRC2_IMM;
          dec.shift     = (f3_op == ALU_SRL) || (f3_op == ALU_SLL);
          dec.reg_write = 1'b1;
        end
      end
      OP_LOAD: begin
        dec.src1_sel  = SRC1_RS1;
        dec.src2_sel  = SRC2_IMM;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_STORE: begin
        dec.src1_sel  = SRC1_RS1;
        dec.src2_sel  = SRC2_IMM;
        dec.mem_write = 1'b1;
      end
      OP_LUI: begin
        dec.alu_op    = ALU_SLL;
        dec.src1_sel  = SRC1_IMM;
        dec.src2_sel  = SRC2_LUI;
        dec.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    dec.illegal = !legal;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: operand selection plus a one-entry valid/ready register feeding the ALU.
module alu_issue_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_b5,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd_out,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            illegal,
  output logic [XLEN-1:0] pc_out
);

  dec_t            dec;
  logic [XLEN-1:0] src1_c;
  logic [XLEN-1:0] src2_raw_c;
  logic [XLEN-1:0] src2_c;
  logic            capture;

  alu_ctrl_decode u_decode (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_b5 (funct7_b5),
    .dec       (dec)
  );

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Operand muxes; shift amounts are truncated to SHAMT_W bits and zero-extended
  always_comb begin
    src1_c     = '0;
    src2_raw_c = '0;
    case (dec.src1_sel)
      SRC1_RS1: src1_c = rs1_data;
      SRC1_IMM: src1_c = imm;
      default:  src1_c = '0;
    endcase
    case (dec.src2_sel)
      SRC2_RS2: src2_raw_c = rs2_data;
      SRC2_IMM: src2_raw_c = imm;
      SRC2_LUI: src2_raw_c = XLEN'(LUI_SHIFT);
      default:  src2_raw_c = '0;
    endcase
    src2_c = dec.shift ? XLEN'(src2_raw_c[SHAMT_W-1:0]) : src2_raw_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_op     <= '0;
      alu_src1   <= '0;
      alu_src2   <= '0;
      store_data <= '0;
      rd_out     <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      illegal    <= 1'b0;
      pc_out     <= '0;
    end else begin
      if (flush)         out_valid <= 1'b0;
      else if (in_ready) out_valid <= in_valid;
      if (capture) begin
        alu_op     <= dec.alu_op;
        alu_src1   <= src1_c;
        alu_src2   <= src2_c;
        store_data <= rs2_data;
        rd_out     <= rd;
        reg_write  <= dec.reg_write && (rd != 5'd0);
        mem_read   <= dec.mem_read;
        mem_write  <= dec.mem_write;
        illegal    <= dec.illegal;
        pc_out     <= pc;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage against an instruction-level reference model.
module tb_alu_issue_stage;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LUI    = 7'b0110111;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] sd;
    logic [31:0] pcv;
    logic [4:0]  rdv;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_b5 = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  alu_op;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] store_data;
  logic [4:0]  rd_out;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        illegal;
  logic [31:0] pc_out;

  int   checks = 0;
  int   failures = 0;
  exp_t m = '0;
  logic m_valid = 1'b0;
  logic m_known = 1'b0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5), .rd(rd), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .store_data(store_data), .rd_out(rd_out), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .illegal(illegal), .pc_out(pc_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  // What one instruction should look like on the ALU side, straight from the ISA rules
  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                 input logic [4:0] rdi, input logic [31:0] pci,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    exp_t e;
    int   code;
    bit   ok;
    logic [31:0] op2;
    e = '0;
    e.rdv = rdi;
    e.pcv = pci;
    e.sd  = b;
    code  = (f3 == 0) ? 0 : (f3 == 5) ? 1 : (f3 == 6) ? 2 : (f3 == 7) ? 3 : (f3 == 1) ? 4 : -1;
    ok    = 1;
    if (opc == R_TYPE || opc == I_TYPE) begin
      op2 = (opc == R_TYPE) ? b : im;
      if (code < 0) ok = 0;
      if (f7 && f3 == 5) ok = 0;
      if (opc == R_TYPE && f7 && f3 == 0) ok = 0;
      if (ok) begin
        e.op = 4'(code);
        e.s1 = a;
        e.s2 = (code == 1 || code == 4) ? op2 % 32 : op2;
        e.rw = 1;
      end
    end else if (opc == LOAD) begin
      e.s1 = a; e.s2 = im; e.mr = 1; e.rw = 1;
    end else if (opc == STORE) begin
      e.s1 = a; e.s2 = im; e.mw = 1;
    end else if (opc == LUI) begin
      e.op = 4; e.s1 = im; e.s2 = 12; e.rw = 1;
    end else begin
      ok = 0;
    end
    e.ill = !ok;
    if (rdi == 0) e.rw = 0;
    return e;
  endfunction

  // One clock: check in_ready, advance the model, then compare registered outputs
  task automatic cycle();
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    if (rst) begin
      m = '0; m_valid = 0; m_known = 1;
    end else if (flush) begin
      m_valid = 0; m_known = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m = model(opcode, funct3, funct7_b5, rd, pc, rs1_data, rs2_data, imm);
      m_valid = 1; m_known = 1;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_known) begin
      check("alu_op", 32'(alu_op), 32'(m.op));
      check("alu_src1", alu_src1, m.s1);
      check("alu_src2", alu_src2, m.s2);
      check("rd_out", 32'(rd_out), 32'(m.rdv));
      check("pc_out", pc_out, m.pcv);
      check("reg_write", 32'(reg_write), 32'(m.rw));
      check("mem_read", 32'(mem_read), 32'(m.mr));
      check("mem_write", 32'(mem_write), 32'(m.mw));
      check("illegal", 32'(illegal), 32'(m.ill));
      if (m.mw || rst) check("store_data", store_data, m.sd);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rdi, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic iv, input logic ordy, input logic fl);
    opcode = opc; funct3 = f3; funct7_b5 = f7; rd = rdi; rs1_data = a; rs2_data = b;
    imm = im; in_valid = iv; out_ready = ordy; flush = fl; rst = 1'b0;
    pc = pc + 32'd4;
  endtask

  initial begin
    logic [31:0] held_src1;
    @(posedge clk);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // ADDI x5, 10, -3
    drive(I_TYPE, 3'b000, 1'b0, 5'd5, 32'd10, 32'd0, 32'hFFFF_FFFD, 1, 1, 0);
    cycle();
    check("addi_src2", alu_src2, 32'hFFFF_FFFD);
    check("addi_src1", alu_src1, 32'd10);

    // SLL R-type keeps only the low 5 bits of rs2
    drive(R_TYPE, 3'b001, 1'b0, 5'd7, 32'h1, 32'h0000_0123, 32'h0, 1, 1, 0);
    cycle();
    check("sll_src2", alu_src2, 32'h3);
    check("sll_op", 32'(alu_op), 32'd4);

    // LUI
    drive(LUI, 3'b000, 1'b0, 5'd9, 32'h55, 32'h66, 32'h000A_BCDE, 1, 1, 0);
    cycle();
    check("lui_src1", alu_src1, 32'h000A_BCDE);
    check("lui_src2", alu_src2, 32'd12);

    // Store then 3 stalled cycles with a competing instruction offered
    drive(STORE, 3'b010, 1'b0, 5'd0, 32'h100, 32'hDEAD_BEEF, 32'h8, 1, 1, 0);
    cycle();
    held_src1 = alu_src1;
    for (int i = 0; i < 3; i++) begin
      drive(R_TYPE, 3'b110, 1'b0, 5'd3, 32'h1, 32'h2, 32'h3, 1, 0, 0);
      cycle();
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_src1", alu_src1, held_src1);
    end
    check("store_data_const", store_data, 32'hDEAD_BEEF);

    // Back-to-back OR then AND
    drive(R_TYPE, 3'b110, 1'b0, 5'd1, 32'hF0, 32'h0F, 32'h0, 1, 1, 0);
    cycle();
    check("b2b_or", 32'(alu_op), 32'd2);
    drive(R_TYPE, 3'b111, 1'b0, 5'd2, 32'hF0, 32'h0F, 32'h0, 1, 1, 0);
    cycle();
    check("b2b_and", 32'(alu_op), 32'd3);
    check("b2b_valid", 32'(out_valid), 32'd1);

    // Stall then flush with a new instruction offered
    drive(LOAD, 3'b010, 1'b0, 5'd4, 32'h20, 32'h0, 32'h4, 1, 0, 0);
    cycle();
    drive(R_TYPE, 3'b000, 1'b0, 5'd6, 32'h1, 32'h1, 32'h0, 1, 0, 1);
    cycle();
    check("flush_valid", 32'(out_valid), 32'd0);

    // SUB is not supported
    drive(R_TYPE, 3'b000, 1'b1, 5'd8, 32'h9, 32'h2, 32'h0, 1, 1, 0);
    cycle();
    check("sub_illegal", 32'(illegal), 32'd1);

    // Reset in the middle of a stall
    drive(I_TYPE, 3'b111, 1'b0, 5'd10, 32'hFF, 32'h0, 32'h0F, 1, 0, 0);
    cycle();
    drive(I_TYPE, 3'b110, 1'b0, 5'd11, 32'hFF, 32'h0, 32'h0F, 1, 0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_mid_stall_ready", 32'(in_ready), 32'd1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] opc;
      case ($urandom_range(0, 5))
        0: opc = R_TYPE;
        1: opc = I_TYPE;
        2: opc = LOAD;
        3: opc = STORE;
        4: opc = LUI;
        default: opc = 7'($urandom);
      endcase
      drive(opc, 3'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom, $urandom,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 19) == 0));
      rst = 1'($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU.
- Takes decoded instruction fields and register-file read data, and generates the 4-bit ALU control code.
- Selects the two ALU operands and holds them, with writeback/memory control, in a one-entry valid/ready register.
- The ALU consumes alu_op, alu_src1 and alu_src2 straight from this block's registers.

Parameters:
- XLEN, 32, datapath width in bits (operands, PC, immediate).
- SHAMT_W, 5, number of low bits of the shift amount that are kept; the upper operand-2 bits are zeroed for shift ops.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  decode presents an instruction this cycle
- in_ready  output  1  stage can accept; equals !out_valid || out_ready
- flush  input  1  kill held and incoming instruction (branch redirect)
- opcode  input  7  instruction[6:0]
- funct3  input  3  instruction[14:12]
- funct7_b5  input  1  instruction[30]
- rd  input  5  destination register index
- pc  input  XLEN  instruction PC, carried through to pc_out
- rs1_data  input  XLEN  register file read port 1
- rs2_data  input  XLEN  register file read port 2
- imm  input  XLEN  sign-extended I/S immediate; for LUI, the 20-bit U field right-justified
- out_valid  output  1  ALU inputs valid
- out_ready  input  1  downstream accepts this cycle
- alu_op  output  4  ALU control: 0 add, 1 srl, 2 or, 3 and, 4 sll
- alu_src1  output  XLEN  ALU operand 1
- alu_src2  output  XLEN  ALU operand 2
- store_data  output  XLEN  rs2_data carried for stores
- rd_out  output  5  destination register
- reg_write  output  1  writeback enable
- mem_read  output  1  load
- mem_write  output  1  store
- illegal  output  1  unsupported encoding
- pc_out  output  XLEN  PC carried through

Behaviour:
- Reset: every output register clears to 0, so out_valid=0 and in_ready=1. Reset overrides flush and capture.

Capture and handshake:
- Capture occurs when in_valid && in_ready && !flush; all output registers load on the next edge and out_valid becomes 1.
- If out_valid && !out_ready, every output holds stable (stall); in_ready=0.
- If out_valid && out_ready && in_valid, a new capture happens in the same edge (back-to-back, no bubble).
- If out_valid && out_ready && !in_valid, out_valid goes to 0.
- Latency: 1 cycle from accepted input to out_valid; throughput 1 per cycle.
- flush=1: next edge out_valid=0, regardless of stall or in_valid. Data registers may hold stale values; only out_valid is guaranteed.

Decode (opcode -> alu_op, src1, src2, controls):
- 0110011 (R):
  - alu_op from funct3: 000 -> 0 (requires funct7_b5=0), 101 -> 1 (requires funct7_b5=0), 110 -> 2, 111 -> 3, 001 -> 4.
  - src1=rs1_data, src2=rs2_data; reg_write=1.
- 0010011 (I): same funct3 map, src2=imm; funct7_b5 checked only for 101 (SRAI -> illegal); reg_write=1.
- 0000011 (load): alu_op 0, src1=rs1_data, src2=imm, mem_read=1, reg_write=1.
- 0100011 (store): alu_op 0, src1=rs1_data, src2=imm, mem_write=1, reg_write=0, store_data=rs2_data.
- 0110111 (LUI): alu_op 4, src1=imm, src2=12, reg_write=1.
- Shift ops (alu_op 1 or 4, except LUI): src2 = zero-extended low SHAMT_W bits; upper bits forced to 0.
- rd=0: reg_write forced 0.

Illegal encodings:
- Any other opcode/funct3/funct7 combination sets illegal=1, alu_op=0, reg_write=mem_read=mem_write=0, src1=src2=0.
- out_valid is still asserted so the exception logic sees it.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_LUI)
  - ALU code constants (ALU_ADD=0, ALU_SRL=1, ALU_OR=2, ALU_AND=3, ALU_SLL=4)
  - LUI shift constant (12)
- One combinational sub-module, alu_ctrl_decode (opcode, funct3, funct7_b5 -> alu_op, operand-select, control, illegal).
- The top level holds the pipeline register, the operand muxes and the handshake.

Test Plan:
- ADDI x5, rs1_data=10, imm=-3, out_ready=1 -> next cycle out_valid=1, alu_op=0, src1=10, src2=0xFFFFFFFD, reg_write=1, rd_out=5.
- SLL R-type, rs2_data=0x00000123 -> alu_op=4, src2=0x00000003; LUI, imm=0xABCDE -> alu_op=4, src1=0x000ABCDE, src2=12.
- Store, rs2_data=0xDEADBEEF, rd=0, out_ready=0 for 3 cycles -> all outputs stable and in_ready=0 for 3 cycles; mem_write=1, reg_write=0, store_data=0xDEADBEEF.
- Back-to-back OR then AND with out_ready=1 -> alu_op 2 then 3 on consecutive cycles with no bubble.
- flush during stall with in_valid=1 -> out_valid=0 next cycle, new instruction not captured; SUB (funct7_b5=1, funct3 000) -> illegal=1, reg_write=0.
- rst asserted mid-stall -> next edge all outputs 0, in_ready=1.
